excess3_bcd_seq_converter: RTL and testbench



---
 rtl/excess3_pkg.sv | 24 ++
 rtl/excess3_bcd_seq_converter_digit_conv.sv | 18 +
 rtl/excess3_bcd_seq_converter.sv | 104 ++++++++++
 tb/tb_excess3_bcd_seq_converter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/excess3_pkg.sv
// Shared definitions for the Excess-3 to BCD conversion slice.
//   E3_DIGIT_W  : width of one Excess-3 / BCD digit
//   E3_OFFSET   : Excess-3 bias removed during conversion
//   E3_MIN/MAX  : inclusive range of legal Excess-3 codes (decimal 0..9)
//   state_t     : controller states
//   is_valid_e3 : range check for a single Excess-3 digit
package excess3_pkg;

  localparam int unsigned E3_DIGIT_W = 4;
  localparam int unsigned E3_OFFSET  = 3;
  localparam int unsigned E3_MIN     = 3;
  localparam int unsigned E3_MAX     = 12;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  function automatic logic is_valid_e3(input logic [E3_DIGIT_W-1:0] d);
    return (d >= E3_DIGIT_W'(E3_MIN)) && (d <= E3_DIGIT_W'(E3_MAX));
  endfunction

endpackage

// File: rtl/excess3_bcd_seq_converter_digit_conv.sv
// Combinational single-digit Excess-3 to BCD converter.
//   e3      : Excess-3 digit in
//   bcd     : BCD digit out, forced to 0 for out-of-range codes
//   invalid : set when e3 is outside E3_MIN..E3_MAX
module excess3_digit_conv
  import excess3_pkg::*;
(
  input  logic [E3_DIGIT_W-1:0] e3,
  output logic [E3_DIGIT_W-1:0] bcd,
  output logic                  invalid
);

  always_comb begin
    invalid = !is_valid_e3(e3);
    bcd     = invalid ? '0 : (e3 - E3_DIGIT_W'(E3_OFFSET));
  end

endmodule

// File: rtl/excess3_bcd_seq_converter.sv
// Multi-digit Excess-3 to BCD converter controller.
// Accepts NUM_DIGITS packed Excess-3 digits, converts one digit per cycle
// (least significant first) through a single shared digit converter, and
// presents packed BCD plus per-digit error flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data digit i = [4i+3:4i]
//   out_valid/out_ready : output handshake for out_bcd/out_err/err_any
//   out_err             : bit i set when input digit i was out of range
//   err_any             : OR of out_err, qualified by out_valid
//   busy                : high while converting or holding a result
module excess3_bcd_seq_converter
  import excess3_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_DIGITS*E3_DIGIT_W-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_DIGITS*E3_DIGIT_W-1:0] out_bcd,
  output logic [NUM_DIGITS-1:0]            out_err,
  output logic                             err_any,
  output logic                             busy
);

  localparam int unsigned W     = NUM_DIGITS * E3_DIGIT_W;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                  state, next_state;
  logic [W-1:0]            shreg;
  logic [IDX_W-1:0]        idx;
  logic                    last_digit;
  logic [E3_DIGIT_W-1:0]   dig_bcd;
  logic                    dig_inv;

  excess3_digit_conv u_conv (
    .e3      (shreg[E3_DIGIT_W-1:0]),
    .bcd     (dig_bcd),
    .invalid (dig_inv)
  );

  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (in_valid && in_ready)   next_state = CONV;
      CONV: if (last_digit)             next_state = DONE;
      DONE: if (out_valid && out_ready) next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the upcoming state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      shreg     <= '0;
      idx       <= '0;
      out_bcd   <= '0;
      out_err   <= '0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg   <= in_data;
            out_bcd <= '0;
            out_err <= '0;
            idx     <= '0;
          end
        end
        CONV: begin
          out_bcd[idx*E3_DIGIT_W +: E3_DIGIT_W] <= dig_bcd;
          out_err[idx]                          <= dig_inv;
          shreg                                 <= shreg >> E3_DIGIT_W;
          // Hold idx on the final digit so it never wraps within a word.
          if (!last_digit) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err_any = out_valid & (|out_err);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_excess3_bcd_seq_converter.sv
module tb_excess3_bcd_seq_converter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_bcd;
  logic [N-1:0] out_err;
  logic         err_any;
  logic         busy;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned accept_cyc = 0;
  int unsigned hs_cyc = 0;

  excess3_bcd_seq_converter #(.NUM_DIGITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .err_any   (err_any),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each digit is its value minus three when it encodes 0..9,
  // otherwise zero with an error flag.
  function automatic void model(input logic [W-1:0] w, output logic [W-1:0] b,
                                output logic [N-1:0] e);
    b = '0;
    e = '0;
    for (int i = 0; i < int'(N); i++) begin
      int d;
      d = int'((w >> (4 * i)) & 16'hF);
      if (d < 3 || d > 12) e[i] = 1'b1;
      else b = b | W'((d - 3) << (4 * i));
    end
  endfunction

  task automatic send_word(input logic [W-1:0] d);
    int unsigned n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    in_data  = '0;
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
  endtask

  // Waits for the result, checks latency and values, optionally holds
  // out_ready low for 'hold' cycles, then completes the handshake.
  task automatic collect(input logic [W-1:0] word, input int unsigned hold);
    logic [W-1:0] eb;
    logic [N-1:0] ee;
    int unsigned n;
    model(word, eb, ee);
    out_ready = (hold == 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", 64'(cyc - accept_cyc), 64'(N));
    check("out_bcd", out_bcd, eb);
    check("out_err", out_err, ee);
    check("err_any", err_any, (ee != '0));
    for (int unsigned k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_out_bcd", out_bcd, eb);
      check("hold_out_err", out_err, ee);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    hs_cyc = cyc;
    check("out_valid_pulse_end", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    logic [31:0] r;
    logic [W-1:0] w;
    int unsigned prev_accept;
    bit saw_valid;

    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_bcd", out_bcd, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_any", err_any, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_first_edge", in_ready, 1);

    send_word(16'h4B73); collect(16'h4B73, 0);
    check("dir1_bcd", out_bcd, 16'h1840);
    send_word(16'hC3F1); collect(16'hC3F1, 0);
    send_word(16'h2D03); collect(16'h2D03, 0);

    // Backpressure with a competing input word waiting
    out_ready = 1'b0;
    send_word(16'h5555);
    in_data  = 16'h6666;
    in_valid = 1'b1;
    collect(16'h5555, 6);
    send_word(16'h6666);
    check("bp_accept_gap", 64'(accept_cyc - hs_cyc), 1);
    collect(16'h6666, 0);

    // Back-to-back
    send_word(16'h3333);
    prev_accept = accept_cyc;
    collect(16'h3333, 0);
    send_word(16'hCCCC);
    check("b2b_gap", 64'(accept_cyc - prev_accept), 64'(N + 2));
    collect(16'hCCCC, 0);

    // Reset in the second CONV cycle
    send_word(16'h1234);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_bcd", out_bcd, 0);
    check("mid_rst_out_err", out_err, 0);
    saw_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_valid", saw_valid, 0);
    send_word(16'h7A94); collect(16'h7A94, 0);
    check("post_rst_bcd", out_bcd, 16'h4761);

    // Randomized words with random backpressure
    for (int i = 0; i < 30; i++) begin
      r = $urandom;
      w = r[W-1:0];
      send_word(w);
      collect(w, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
